// File: rtl/cpu.sv
// Single-cycle RV32I core: one instruction per clk, byte-lane store port, combinational fetch/load.
// Define CPU_IRQ_EN to add a level interrupt (vector 0x4) with IE/EPC and MRET return.
module cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id,
    input  logic [31:0] mrd,
    input  logic        irq,
    output logic [31:0] ia,
    output logic        wr,
    output logic [31:0] data_out,
    output logic [31:0] addr_out,
    output logic [15:0] wr_mask
);
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;

    logic [31:0] r_pc;
    logic [31:0] r_x [0:31];

    logic [6:0]  w_op, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_a, w_b, w_opb, w_alu, w_ea, w_pc4, w_npc, w_wd, w_ld_val;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic        w_alt, w_take, w_we, w_st, w_ld, w_op_ok, w_opi_ok;

    assign w_op  = id[6:0];
    assign w_rd  = id[11:7];
    assign w_f3  = id[14:12];
    assign w_rs1 = id[19:15];
    assign w_rs2 = id[24:20];
    assign w_f7  = id[31:25];

    assign w_imm_i = {{20{id[31]}}, id[31:20]};
    assign w_imm_s = {{20{id[31]}}, id[31:25], id[11:7]};
    assign w_imm_b = {{19{id[31]}}, id[31], id[7], id[30:25], id[11:8], 1'b0};
    assign w_imm_u = {id[31:12], 12'b0};
    assign w_imm_j = {{11{id[31]}}, id[31], id[19:12], id[20], id[30:21], 1'b0};

    assign w_a   = (w_rs1 == 5'd0) ? 32'd0 : r_x[w_rs1];
    assign w_b   = (w_rs2 == 5'd0) ? 32'd0 : r_x[w_rs2];
    assign w_pc4 = r_pc + 32'd4;
    assign ia    = r_pc;

    // funct7 only qualifies SUB/SRA; other encodings are rejected as NOPs.
    assign w_op_ok  = (w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
    assign w_opi_ok = (w_f3 == 3'd1) ? (w_f7 == 7'h00) :
                      (w_f3 == 3'd5) ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1;
    assign w_opb    = (w_op == OP_REG) ? w_b : w_imm_i;
    assign w_alt    = w_f7[5] && ((w_op == OP_REG) || (w_f3 == 3'd5));

    always_comb begin
        w_alu = 32'd0;
        case (w_f3)
            3'd0: w_alu = w_alt ? (w_a - w_opb) : (w_a + w_opb);
            3'd1: w_alu = w_a << w_opb[4:0];
            3'd2: w_alu = {31'd0, $signed(w_a) < $signed(w_opb)};
            3'd3: w_alu = {31'd0, w_a < w_opb};
            3'd4: w_alu = w_a ^ w_opb;
            3'd5: w_alu = w_alt ? $unsigned($signed(w_a) >>> w_opb[4:0]) : (w_a >> w_opb[4:0]);
            3'd6: w_alu = w_a | w_opb;
            default: w_alu = w_a & w_opb;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (w_f3)
            3'd0: w_take = (w_a == w_b);
            3'd1: w_take = (w_a != w_b);
            3'd4: w_take = ($signed(w_a) < $signed(w_b));
            3'd5: w_take = ($signed(w_a) >= $signed(w_b));
            3'd6: w_take = (w_a < w_b);
            3'd7: w_take = (w_a >= w_b);
            default: w_take = 1'b0;
        endcase
    end

    assign w_ea      = w_a + ((w_op == OP_STORE) ? w_imm_s : w_imm_i);
    assign w_ld_byte = mrd[{w_ea[1:0], 3'b000} +: 8];
    assign w_ld_half = w_ea[1] ? mrd[31:16] : mrd[15:0];

    always_comb begin
        w_ld_val = mrd;
        case (w_f3)
            3'd0: w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'd1: w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
            3'd4: w_ld_val = {24'd0, w_ld_byte};
            3'd5: w_ld_val = {16'd0, w_ld_half};
            default: w_ld_val = mrd;
        endcase
    end

`ifdef CPU_IRQ_EN
    logic        r_ie;
    logic [31:0] r_epc;
    logic        w_irq_take, w_mret;
    assign w_irq_take = irq && r_ie;
    assign w_mret     = (id == 32'h30200073);
`endif

    always_comb begin
        w_npc = w_pc4;
        w_we  = 1'b0;
        w_wd  = 32'd0;
        w_st  = 1'b0;
        w_ld  = 1'b0;
        case (w_op)
            OP_LUI:   begin w_we = 1'b1; w_wd = w_imm_u; end
            OP_AUIPC: begin w_we = 1'b1; w_wd = r_pc + w_imm_u; end
            OP_JAL:   begin w_we = 1'b1; w_wd = w_pc4; w_npc = r_pc + w_imm_j; end
            OP_JALR:
                if (w_f3 == 3'd0) begin
                    w_we  = 1'b1;
                    w_wd  = w_pc4;
                    w_npc = (w_a + w_imm_i) & ~32'd1;
                end
            OP_BR:
                if (w_take) w_npc = r_pc + w_imm_b;
            OP_LOAD:
                if (w_f3 != 3'd3 && w_f3 != 3'd6 && w_f3 != 3'd7) begin
                    w_ld = 1'b1;
                    w_we = 1'b1;
                    w_wd = w_ld_val;
                end
            OP_STORE:
                if (w_f3 <= 3'd2) w_st = 1'b1;
            OP_IMM:
                if (w_opi_ok) begin w_we = 1'b1; w_wd = w_alu; end
            OP_REG:
                if (w_op_ok) begin w_we = 1'b1; w_wd = w_alu; end
            default: ;
        endcase
`ifdef CPU_IRQ_EN
        if (w_mret) w_npc = r_epc;
        // A taken interrupt discards the instruction on the bus this cycle.
        if (w_irq_take) begin
            w_we  = 1'b0;
            w_st  = 1'b0;
            w_npc = 32'h0000_0004;
        end
`endif
    end

    // Reset gates the strobe combinationally so nothing commits while held.
    always_comb begin
        wr       = w_st && !reset;
        addr_out = (w_ld || w_st) ? w_ea : 32'd0;
        data_out = 32'd0;
        wr_mask  = 16'd0;
        if (wr) begin
            case (w_f3)
                3'd0: begin
                    data_out = {4{w_b[7:0]}};
                    wr_mask  = 16'h0001 << w_ea[1:0];
                end
                3'd1: begin
                    data_out = {2{w_b[15:0]}};
                    wr_mask  = w_ea[1] ? 16'h000C : 16'h0003;
                end
                default: begin
                    data_out = w_b;
                    wr_mask  = 16'h000F;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= 32'd0;
            for (int i = 0; i < 32; i++) r_x[i] <= 32'd0;
        end else begin
            r_pc <= w_npc;
            if (w_we && w_rd != 5'd0) r_x[w_rd] <= w_wd;
        end
    end

`ifdef CPU_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ie  <= 1'b1;
            r_epc <= 32'd0;
        end else if (w_irq_take) begin
            r_ie  <= 1'b0;
            r_epc <= r_pc;
        end else if (w_mret) begin
            r_ie  <= 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_unused = irq;
`endif
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: store/load lanes, ALU, branches/jumps, reset and (optionally) interrupts.
module tb_cpu;
    logic        clk, reset, irq, wr;
    logic [31:0] id, mrd, ia, data_out, addr_out;
    logic [15:0] wr_mask;
    logic [31:0] imem [0:63];

    logic [31:0] e_wr [0:63];
    logic [31:0] e_addr [0:63];
    logic [31:0] e_data [0:63];
    logic [31:0] e_mask [0:63];

    int n_chk = 0;
    int n_pass = 0;

    cpu dut (
        .clk(clk), .reset(reset), .id(id), .mrd(mrd), .irq(irq),
        .ia(ia), .wr(wr), .data_out(data_out), .addr_out(addr_out), .wr_mask(wr_mask)
    );

    assign id = imem[ia[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        logic [31:0] m, d, o;
        m = imm20; d = rd; o = op;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
    endfunction

    task automatic put(input int idx, input logic [31:0] ins, input logic [31:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        imem[idx] = ins; e_wr[idx] = w; e_addr[idx] = a; e_data[idx] = d; e_mask[idx] = m;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Reset lands between edges so an in-flight instruction is aborted.
    task automatic rst_on();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_ia", ia, 32'h0);
        chk("rst_async_wr", 32'(wr), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_held_ia", ia, 32'h0);
        chk("rst_held_wr", 32'(wr), 32'h0);
    endtask

    task automatic rst_off();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rel_ia", ia, 32'h0);
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 64; i++) put(i, 32'h0000_0013, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        irq   = 1'b0;
        mrd   = 32'hFFFF_FFFF;

        // ---------------- phase A: data path, loads, stores, ALU ----------------
        clr_prog();
        put(0,  enc_i(5, 0, 0, 1, 'h13), 0, 0, 0, 0);
        put(1,  enc_r(0, 1, 1, 0, 2), 0, 0, 0, 0);
        put(2,  enc_s(0, 2, 0, 2), 1, 0, 32'h0000_000A, 32'hF);
        put(3,  enc_s(3, 2, 0, 0), 1, 3, 32'h0A0A_0A0A, 32'h8);
        put(4,  enc_s(2, 2, 0, 1), 1, 2, 32'h000A_000A, 32'hC);
        put(5,  enc_i(3, 0, 4, 3, 'h03), 0, 3, 0, 0);
        put(6,  enc_i(3, 0, 0, 4, 'h03), 0, 3, 0, 0);
        put(7,  enc_i(2, 0, 1, 5, 'h03), 0, 2, 0, 0);
        put(8,  enc_s(0, 3, 0, 2), 1, 0, 32'h0000_00FF, 32'hF);
        put(9,  enc_s(4, 4, 0, 2), 1, 4, 32'hFFFF_FFFF, 32'hF);
        put(10, enc_s(8, 5, 0, 2), 1, 8, 32'hFFFF_FFFF, 32'hF);
        put(11, enc_i(0, 0, 1, 6, 'h03), 0, 0, 0, 0);
        put(12, enc_i(2, 0, 5, 7, 'h03), 0, 2, 0, 0);
        put(13, enc_i(1, 0, 0, 8, 'h03), 0, 1, 0, 0);
        put(14, enc_i(2, 0, 2, 9, 'h03), 0, 2, 0, 0);
        put(15, enc_s(0, 6, 0, 2), 1, 0, 32'hFFFF_8765, 32'hF);
        put(16, enc_s(0, 7, 0, 2), 1, 0, 32'h0000_1234, 32'hF);
        put(17, enc_s(0, 8, 0, 2), 1, 0, 32'hFFFF_FF87, 32'hF);
        put(18, enc_s(6, 9, 0, 2), 1, 6, 32'h1234_8765, 32'hF);
        put(19, enc_u('h80000, 10, 'h37), 0, 0, 0, 0);
        put(20, enc_i('h404, 10, 5, 11, 'h13), 0, 0, 0, 0);
        put(21, enc_r(0, 10, 1, 3, 12), 0, 0, 0, 0);
        put(22, enc_r(0, 10, 1, 2, 13), 0, 0, 0, 0);
        put(23, enc_r('h20, 2, 1, 0, 14), 0, 0, 0, 0);
        put(24, enc_u(1, 15, 'h17), 0, 0, 0, 0);
        put(25, enc_i(7, 0, 0, 0, 'h13), 0, 0, 0, 0);
        put(26, 32'hFFFF_FFFF, 0, 0, 0, 0);
        put(27, enc_s(0, 11, 0, 2), 1, 0, 32'hF800_0000, 32'hF);
        put(28, enc_s(0, 12, 0, 2), 1, 0, 32'h0000_0001, 32'hF);
        put(29, enc_s(0, 13, 0, 2), 1, 0, 32'h0000_0000, 32'hF);
        put(30, enc_s(0, 14, 0, 2), 1, 0, 32'hFFFF_FFFB, 32'hF);
        put(31, enc_s(0, 15, 0, 2), 1, 0, 32'h0000_1060, 32'hF);
        put(32, enc_s(0, 0, 0, 2), 1, 0, 32'h0000_0000, 32'hF);
        put(33, enc_r(0, 1, 10, 5, 16), 0, 0, 0, 0);
        put(34, enc_i(-1, 2, 4, 17, 'h13), 0, 0, 0, 0);
        put(35, enc_r(0, 1, 1, 1, 18), 0, 0, 0, 0);
        put(36, enc_r(0, 2, 1, 6, 19), 0, 0, 0, 0);
        put(37, enc_r(0, 2, 1, 7, 20), 0, 0, 0, 0);
        put(38, enc_s(0, 16, 0, 2), 1, 0, 32'h0400_0000, 32'hF);
        put(39, enc_s(0, 17, 0, 2), 1, 0, 32'hFFFF_FFF5, 32'hF);
        put(40, enc_s(0, 18, 0, 2), 1, 0, 32'h0000_00A0, 32'hF);
        put(41, enc_s(0, 19, 0, 2), 1, 0, 32'h0000_000F, 32'hF);
        put(42, enc_s(0, 20, 0, 2), 1, 0, 32'h0000_0000, 32'hF);
        put(43, enc_j(0, 0), 0, 0, 0, 0);

        rst_on();
        rst_off();
        for (int i = 0; i < 44; i++) begin
            mrd = (i < 8) ? 32'hFFFF_FFFF : 32'h1234_8765;
            #1;
            chk($sformatf("A%0d_ia", i), ia, 32'(i * 4));
            chk($sformatf("A%0d_wr", i), 32'(wr), e_wr[i]);
            chk($sformatf("A%0d_addr", i), addr_out, e_addr[i]);
            chk($sformatf("A%0d_data", i), data_out, e_data[i]);
            chk($sformatf("A%0d_mask", i), 32'(wr_mask), e_mask[i]);
            step();
        end
        chk("A_jal_self", ia, 32'h0000_00AC);

        // ---------------- phase B: branches and jumps ----------------
        rst_on();
        clr_prog();
        imem[0]  = enc_i(-1, 0, 0, 2, 'h13);
        imem[1]  = enc_i(3, 0, 0, 3, 'h13);
        imem[4]  = enc_b(8, 0, 0, 0);
        imem[5]  = enc_i('h11, 1, 0, 0, 'h67);
        imem[6]  = enc_j(-8, 1);
        imem[11] = enc_b(8, 0, 0, 1);
        imem[12] = enc_b(16, 0, 2, 4);
        imem[16] = enc_b(8, 0, 2, 6);
        imem[17] = enc_b(8, 2, 3, 5);
        imem[19] = enc_b(8, 2, 3, 7);
        imem[20] = enc_b(-80, 2, 3, 1);
        rst_off();
        begin
            logic [31:0] seq1 [0:5];
            logic [31:0] seq2 [0:7];
            seq1 = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h10};
            seq2 = '{32'h14, 32'h2C, 32'h30, 32'h40, 32'h44, 32'h4C, 32'h50, 32'h00};
            for (int i = 0; i < 6; i++) begin
                step();
                chk($sformatf("B1_%0d_ia", i), ia, seq1[i]);
            end
            imem[4] = enc_s(0, 1, 0, 2);
            #1;
            chk("B_jal_link_wr", 32'(wr), 32'h1);
            chk("B_jal_link", data_out, 32'h0000_001C);
            for (int i = 0; i < 8; i++) begin
                step();
                chk($sformatf("B2_%0d_ia", i), ia, seq2[i]);
            end
        end

        // ---------------- phase C: interrupt / MRET ----------------
        rst_on();
        clr_prog();
        imem[0] = enc_i(9, 0, 0, 1, 'h13);
        imem[8] = enc_s(0, 1, 0, 2);
        imem[9] = enc_j(0, 0);
        rst_off();
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("C_run%0d_ia", i), ia, 32'(i * 4));
        end
        irq = 1'b1;
`ifdef CPU_IRQ_EN
        imem[2] = 32'h3020_0073;
        #1;
        chk("C_irq_discard_wr", 32'(wr), 32'h0);
        chk("C_irq_discard_mask", 32'(wr_mask), 32'h0);
        step();
        chk("C_irq_vec", ia, 32'h04);
        step();
        chk("C_irq_masked", ia, 32'h08);
        step();
        chk("C_mret_ia", ia, 32'h20);
        chk("C_retake_wr", 32'(wr), 32'h0);
        step();
        chk("C_retake_vec", ia, 32'h04);
        irq = 1'b0;
        step();
        chk("C_mret2_at", ia, 32'h08);
        step();
        chk("C_mret2_ia", ia, 32'h20);
        chk("C_resume_wr", 32'(wr), 32'h1);
        chk("C_resume_data", data_out, 32'h9);
        step();
        chk("C_resume_next", ia, 32'h24);
`else
        imem[9] = 32'h3020_0073;
        #1;
        chk("C_irq_ignored_wr", 32'(wr), 32'h1);
        chk("C_irq_ignored_data", data_out, 32'h9);
        step();
        chk("C_irq_ignored_ia", ia, 32'h24);
        step();
        chk("C_mret_nop_ia", ia, 32'h28);
`endif
        irq = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
